ram_arbiter: RTL and testbench

- Shares the single data RAM between two requesters: the CPU controller port and a loader port (program/data preload, debug read-back).
- Sits between both requesters and the RAM's ena/read/write/address/data pins.
- Issues one single-cycle RAM access per grant.
- CPU has fixed priority, bounded by a starvation limit that guarantees loader progress.

---
 rtl/ram_arbiter_pkg.sv | 32 +++
 rtl/ram_port_mux.sv | 64 ++++++
 rtl/ram_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: owner codes, FSM states and default sizing.
package ram_arbiter_pkg;

    // Default sizing; matches the CPU's data RAM.
    localparam int unsigned RAM_AW = 5;
    localparam int unsigned RAM_DW = 8;

    // Owner codes driven on the owner_o port.
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_LD   = 2'b10;

    // Arbiter FSM states; the encodings line up with the owner codes.
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StCpuAcc = 2'b01,
        StLdAcc  = 2'b10
    } arb_state_e;

    // Owner code for the access being performed in a given state.
    function automatic logic [1:0] state_to_owner(input arb_state_e st);
        logic [1:0] own;
        own = OWN_NONE;
        case (st)
            StCpuAcc: own = OWN_CPU;
            StLdAcc:  own = OWN_LD;
            default:  own = OWN_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/ram_port_mux.sv
// Registered select of the winning requester's access fields (we/addr/wdata).
// Fields are zeroed when nobody wins so the RAM pins sit quiet while idle.
module ram_port_mux
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned AW = RAM_AW,
    parameter int unsigned DW = RAM_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  arb_state_e    sel_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_wdata_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o
);

    logic          we_d, we_q;
    logic [AW-1:0] addr_d, addr_q;
    logic [DW-1:0] wdata_d, wdata_q;

    // Pick the fields of the requester the arbiter just selected.
    always_comb begin
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (sel_i)
            StCpuAcc: begin
                we_d    = cpu_we_i;
                addr_d  = cpu_addr_i;
                wdata_d = cpu_wdata_i;
            end
            StLdAcc: begin
                we_d    = ld_we_i;
                addr_d  = ld_addr_i;
                wdata_d = ld_wdata_i;
            end
            default: ;
        endcase
    end

    // Hold the selected fields for the access cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single data RAM: CPU has fixed priority, but after
// STARVE_LIM consecutive CPU wins against a waiting loader the loader is served.
// One single-cycle RAM access per grant; read data returns one cycle later.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned AW         = RAM_AW,
    parameter int unsigned DW         = RAM_DW,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    // CPU port
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_gnt_o,
    output logic          cpu_rvalid_o,
    output logic [DW-1:0] cpu_rdata_o,
    // Loader port
    input  logic          ld_req_i,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_wdata_i,
    output logic          ld_gnt_o,
    output logic          ld_rvalid_o,
    output logic [DW-1:0] ld_rdata_o,
    // RAM pins
    output logic          ram_ena_o,
    output logic          ram_read_o,
    output logic          ram_write_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic [1:0]    owner_o
);

    localparam int unsigned CntW = $clog2(STARVE_LIM + 1);
    localparam logic [CntW-1:0] StarveLim = CntW'(STARVE_LIM);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic [1:0]      rd_own_q, rd_own_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]   ld_rdata_q, ld_rdata_d;

    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          access;
    logic          loader_due;

    assign loader_due = ld_req_i && (starve_q == StarveLim);

    // Arbitration: CPU first unless the loader has waited out the starvation limit.
    always_comb begin
        state_d = StIdle;
        if (cpu_req_i && !loader_due) begin
            state_d = StCpuAcc;
        end else if (ld_req_i) begin
            state_d = StLdAcc;
        end
    end

    // Count CPU wins over a waiting loader; any loader win or idle loader clears it.
    always_comb begin
        starve_d = '0;
        if (ld_req_i && (state_d == StCpuAcc)) begin
            starve_d = (starve_q == StarveLim) ? starve_q : starve_q + CntW'(1);
        end
    end

    // Winner's fields are captured at the same edge as the state.
    ram_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_port_mux (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sel_i       (state_d),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .ld_we_i     (ld_we_i),
        .ld_addr_i   (ld_addr_i),
        .ld_wdata_i  (ld_wdata_i),
        .we_o        (acc_we),
        .addr_o      (acc_addr),
        .wdata_o     (acc_wdata)
    );

    assign access = (state_q != StIdle);

    // Track which port (if any) is owed read data next cycle, and hold the last data per port.
    always_comb begin
        rd_own_d    = (access && !acc_we) ? state_to_owner(state_q) : OWN_NONE;
        cpu_rdata_d = (rd_own_q == OWN_CPU) ? ram_rdata_i : cpu_rdata_q;
        ld_rdata_d  = (rd_own_q == OWN_LD)  ? ram_rdata_i : ld_rdata_q;
    end

    // State, starvation counter and read-return registers; reset drops any pending rvalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            rd_own_q    <= OWN_NONE;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            rd_own_q    <= rd_own_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    // Output decode: everything derives from registered state, so outputs are glitch-free.
    always_comb begin
        cpu_gnt_o    = (state_q == StCpuAcc);
        ld_gnt_o     = (state_q == StLdAcc);
        ram_ena_o    = access;
        ram_read_o   = access && !acc_we;
        ram_write_o  = access && acc_we;
        ram_addr_o   = acc_addr;
        ram_wdata_o  = acc_wdata;
        owner_o      = state_to_owner(state_q);
        cpu_rvalid_o = (rd_own_q == OWN_CPU);
        ld_rvalid_o  = (rd_own_q == OWN_LD);
        // RAM data arrives in the rvalid cycle; pass it through then, hold it afterwards.
        cpu_rdata_o  = cpu_rvalid_o ? ram_rdata_i : cpu_rdata_q;
        ld_rdata_o   = ld_rvalid_o ? ram_rdata_i : ld_rdata_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, ld_req, ld_we;
    logic [4:0] cpu_addr, ld_addr;
    logic [7:0] cpu_wdata, ld_wdata;
    logic       cpu_gnt, cpu_rvalid, ld_gnt, ld_rvalid;
    logic [7:0] cpu_rdata, ld_rdata;
    logic       ram_ena, ram_read, ram_write;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [1:0] owner;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .AW         (5),
        .DW         (8),
        .STARVE_LIM (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_gnt_o    (cpu_gnt),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_rdata_o  (cpu_rdata),
        .ld_req_i     (ld_req),
        .ld_we_i      (ld_we),
        .ld_addr_i    (ld_addr),
        .ld_wdata_i   (ld_wdata),
        .ld_gnt_o     (ld_gnt),
        .ld_rvalid_o  (ld_rvalid),
        .ld_rdata_o   (ld_rdata),
        .ram_ena_o    (ram_ena),
        .ram_read_o   (ram_read),
        .ram_write_o  (ram_write),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata),
        .owner_o      (owner)
    );

    // Synchronous RAM model: data for a read strobe appears the following cycle.
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        if (ram_read)  ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic       rst;
        logic       creq, cwe;
        logic [4:0] caddr;
        logic [7:0] cwd;
        logic       lreq, lwe;
        logic [4:0] laddr;
        logic [7:0] lwd;
        logic       cg, lg, rd, wr;
        logic [4:0] ra;
        logic [7:0] rw;
        logic [1:0] own;
        logic       cv;
        logic [7:0] cd;
        logic       lv;
        logic [7:0] ldd;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic creq, input logic cwe, input logic [4:0] ca,
                         input logic [7:0] cw, input logic lreq, input logic lwe,
                         input logic [4:0] la, input logic [7:0] lw);
        rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cw;
        ld_req = lreq; ld_we = lwe; ld_addr = la; ld_wdata = lw;
    endtask

    task automatic check_gnt(input string tag, input logic cg, input logic lg,
                             input logic [1:0] own);
        chk({tag, ".cpu_gnt"}, 32'(cpu_gnt), 32'(cg));
        chk({tag, ".ld_gnt"}, 32'(ld_gnt), 32'(lg));
        chk({tag, ".owner"}, 32'(owner), 32'(own));
        chk({tag, ".one_gnt"}, 32'(cpu_gnt & ld_gnt), 32'd0);
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check_gnt(tag, v.cg, v.lg, v.own);
        chk({tag, ".ram_ena"}, 32'(ram_ena), 32'(v.cg | v.lg));
        chk({tag, ".ram_read"}, 32'(ram_read), 32'(v.rd));
        chk({tag, ".ram_write"}, 32'(ram_write), 32'(v.wr));
        chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(v.ra));
        chk({tag, ".ram_wdata"}, 32'(ram_wdata), 32'(v.rw));
        chk({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(v.cv));
        chk({tag, ".cpu_rdata"}, 32'(cpu_rdata), 32'(v.cd));
        chk({tag, ".ld_rvalid"}, 32'(ld_rvalid), 32'(v.lv));
        chk({tag, ".ld_rdata"}, 32'(ld_rdata), 32'(v.ldd));
    endtask

    initial begin
        // Fields: rst | cpu req,we,addr,wdata | ld req,we,addr,wdata |
        //         expected after the edge: cg,lg,rd,wr,addr,wdata,owner | cv,cd | lv,ldd
        // Reset with both requests high.
        vecs[0]  = '{1'b1, 1'b1,1'b0,5'h01,8'h00, 1'b1,1'b0,5'h02,8'h00,
                     1'b0,1'b0,1'b0,1'b0,5'h00,8'h00,2'b00, 1'b0,8'h00, 1'b0,8'h00};
        vecs[1]  = '{1'b1, 1'b1,1'b0,5'h01,8'h00, 1'b1,1'b0,5'h02,8'h00,
                     1'b0,1'b0,1'b0,1'b0,5'h00,8'h00,2'b00, 1'b0,8'h00, 1'b0,8'h00};
        // Out of reset: both request, CPU write 03<=A5 wins.
        vecs[2]  = '{1'b0, 1'b1,1'b1,5'h03,8'hA5, 1'b1,1'b1,5'h0A,8'h5A,
                     1'b1,1'b0,1'b0,1'b1,5'h03,8'hA5,2'b01, 1'b0,8'h00, 1'b0,8'h00};
        // CPU drops after its grant; loader write 0A<=5A.
        vecs[3]  = '{1'b0, 1'b0,1'b0,5'h00,8'h00, 1'b1,1'b1,5'h0A,8'h5A,
                     1'b0,1'b1,1'b0,1'b1,5'h0A,8'h5A,2'b10, 1'b0,8'h00, 1'b0,8'h00};
        // CPU read of 03.
        vecs[4]  = '{1'b0, 1'b1,1'b0,5'h03,8'h00, 1'b0,1'b0,5'h00,8'h00,
                     1'b1,1'b0,1'b1,1'b0,5'h03,8'h00,2'b01, 1'b0,8'h00, 1'b0,8'h00};
        // Loader read of 0A while CPU read data returns.
        vecs[5]  = '{1'b0, 1'b0,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h0A,8'h00,
                     1'b0,1'b1,1'b1,1'b0,5'h0A,8'h00,2'b10, 1'b1,8'hA5, 1'b0,8'h00};
        // Idle: loader data returns, CPU data held.
        vecs[6]  = '{1'b0, 1'b0,1'b0,5'h00,8'h00, 1'b0,1'b0,5'h00,8'h00,
                     1'b0,1'b0,1'b0,1'b0,5'h00,8'h00,2'b00, 1'b0,8'hA5, 1'b1,8'h5A};
        vecs[7]  = '{1'b0, 1'b0,1'b0,5'h00,8'h00, 1'b0,1'b0,5'h00,8'h00,
                     1'b0,1'b0,1'b0,1'b0,5'h00,8'h00,2'b00, 1'b0,8'hA5, 1'b0,8'h5A};
        // Back-to-back CPU write 07<=3C then read 07.
        vecs[8]  = '{1'b0, 1'b1,1'b1,5'h07,8'h3C, 1'b0,1'b0,5'h00,8'h00,
                     1'b1,1'b0,1'b0,1'b1,5'h07,8'h3C,2'b01, 1'b0,8'hA5, 1'b0,8'h5A};
        vecs[9]  = '{1'b0, 1'b1,1'b0,5'h07,8'h00, 1'b0,1'b0,5'h00,8'h00,
                     1'b1,1'b0,1'b1,1'b0,5'h07,8'h00,2'b01, 1'b0,8'hA5, 1'b0,8'h5A};
        vecs[10] = '{1'b0, 1'b0,1'b0,5'h00,8'h00, 1'b0,1'b0,5'h00,8'h00,
                     1'b0,1'b0,1'b0,1'b0,5'h00,8'h00,2'b00, 1'b1,8'h3C, 1'b0,8'h5A};
        vecs[11] = '{1'b0, 1'b0,1'b0,5'h00,8'h00, 1'b0,1'b0,5'h00,8'h00,
                     1'b0,1'b0,1'b0,1'b0,5'h00,8'h00,2'b00, 1'b0,8'h3C, 1'b0,8'h5A};

        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].lreq, vecs[i].lwe, vecs[i].laddr, vecs[i].lwd);
            step();
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Contention: both held high; CPU x4 then loader, repeating.
        drive(1'b0, 1'b1, 1'b1, 5'h01, 8'h11, 1'b1, 1'b1, 5'h02, 8'h22);
        for (int k = 0; k < 15; k++) begin
            logic exp_ld;
            exp_ld = ((k % 5) == 4);
            step();
            check_gnt($sformatf("cont%0d", k), !exp_ld, exp_ld, exp_ld ? 2'b10 : 2'b01);
        end

        // Loader pulses for one cycle while the CPU is granted: no loader grant.
        drive(1'b0, 1'b1, 1'b1, 5'h01, 8'h11, 1'b1, 1'b1, 5'h02, 8'h22);
        step();
        check_gnt("pulse0", 1'b1, 1'b0, 2'b01);
        drive(1'b0, 1'b1, 1'b1, 5'h01, 8'h11, 1'b0, 1'b1, 5'h02, 8'h22);
        step();
        check_gnt("pulse1", 1'b1, 1'b0, 2'b01);
        // Counter must have cleared: a fresh contention run gives four CPU grants first.
        drive(1'b0, 1'b1, 1'b1, 5'h01, 8'h11, 1'b1, 1'b1, 5'h02, 8'h22);
        for (int k = 0; k < 5; k++) begin
            logic exp_ld;
            exp_ld = (k == 4);
            step();
            check_gnt($sformatf("recont%0d", k), !exp_ld, exp_ld, exp_ld ? 2'b10 : 2'b01);
        end

        // Both requests low: idle.
        drive(1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
        step();
        check_gnt("idle", 1'b0, 1'b0, 2'b00);
        chk("idle.ram_ena", 32'(ram_ena), 32'd0);

        // Reset in the cycle a CPU read is granted: no rvalid, strobes drop.
        drive(1'b0, 1'b1, 1'b0, 5'h07, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
        step();
        check_gnt("rstrd.grant", 1'b1, 1'b0, 2'b01);
        chk("rstrd.ram_read", 32'(ram_read), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
        step();
        check_gnt("rstrd.after", 1'b0, 1'b0, 2'b00);
        chk("rstrd.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rstrd.ram_ena", 32'(ram_ena), 32'd0);
        chk("rstrd.ram_read", 32'(ram_read), 32'd0);
        chk("rstrd.ram_write", 32'(ram_write), 32'd0);
        chk("rstrd.cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rstrd.ld_rdata", 32'(ld_rdata), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00);
        step();
        chk("rstrd.late_rvalid", 32'(cpu_rvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
